// File: rtl/line_buffer_ctrl_if.sv
// Bundle of the pixel input, line-buffer control/data and window output signals
// of line_buffer_ctrl.
//   slave  : the controller (consumes pixels and buffer data, drives strobes/window)
//   master : the surrounding environment (pixel source and the four line buffers)
// Ports carried:
//   i_pixel_data[8], i_pixel_valid       : incoming pixel stream
//   lb_wr_data[8], lb_wr_valid[4]        : write port to the four buffers
//   lb_rd[4]                             : read-advance strobes to the buffers
//   lb0_data..lb3_data[24]               : buffer outputs {p[c],p[c+1],p[c+2]}
//   o_window[72], o_window_valid         : 3x3 window and qualifier
//   o_intr, o_overflow                   : line-freed pulse, sticky drop flag
interface line_buffer_ctrl_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_valid;
    logic [7:0]  lb_wr_data;
    logic [3:0]  lb_wr_valid;
    logic [3:0]  lb_rd;
    logic [23:0] lb0_data;
    logic [23:0] lb1_data;
    logic [23:0] lb2_data;
    logic [23:0] lb3_data;
    logic [71:0] o_window;
    logic        o_window_valid;
    logic        o_intr;
    logic        o_overflow;

    modport slave (
        input  i_pixel_data, i_pixel_valid,
        input  lb0_data, lb1_data, lb2_data, lb3_data,
        output lb_wr_data, lb_wr_valid, lb_rd,
        output o_window, o_window_valid, o_intr, o_overflow
    );

    modport master (
        output i_pixel_data, i_pixel_valid,
        output lb0_data, lb1_data, lb2_data, lb3_data,
        input  lb_wr_data, lb_wr_valid, lb_rd,
        input  o_window, o_window_valid, o_intr, o_overflow
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// Sequencer for four rotating line buffers feeding a 3x3 filter.
// Pixels are written one line per buffer in rotation; once three lines are
// stored, three buffers are read in lockstep to build one 72-bit window per
// clock, and o_intr pulses after each consumed line.
// Ports:
//   clk      : system clock, rising edge
//   reset_n  : asynchronous active-low reset (shared with the line buffers)
//   bus      : line_buffer_ctrl_if.slave (pixel in, buffer control, window out)
module line_buffer_ctrl #(
    parameter int unsigned IMAGE_WIDTH = 512
) (
    input  logic                clk,
    input  logic                reset_n,
    line_buffer_ctrl_if.slave   bus
);

    localparam int unsigned COL_W    = $clog2(IMAGE_WIDTH);
    localparam int unsigned FILL_W   = $clog2(4 * IMAGE_WIDTH + 1);
    localparam int unsigned FILL_MAX = 4 * IMAGE_WIDTH;
    localparam int unsigned FILL_RD  = 3 * IMAGE_WIDTH;

    localparam logic [COL_W-1:0]  COL_LAST   = COL_W'(IMAGE_WIDTH - 1);
    localparam logic [COL_W-1:0]  COL_VLAST  = COL_W'(IMAGE_WIDTH - 3);
    localparam logic [FILL_W-1:0] FILL_FULL  = FILL_W'(FILL_MAX);
    localparam logic [FILL_W-1:0] FILL_START = FILL_W'(FILL_RD);
    localparam logic [FILL_W-1:0] FILL_ONE   = FILL_W'(1);

    typedef enum logic {IDLE, READ} state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          wr_sel;
    logic [1:0]          rd_sel;
    logic [1:0]          rd_sel1;
    logic [1:0]          rd_sel2;
    logic [COL_W-1:0]    wr_col;
    logic [COL_W-1:0]    rd_col;
    logic [FILL_W-1:0]   fill;
    logic                full;
    logic                accept;
    logic                rd_cycle;
    logic                rd_last;
    logic [3:0]          rd_mask;
    logic [23:0]         lb_data [4];
    logic [71:0]         window;
    logic                window_valid;
    logic                intr;
    logic                overflow;

    assign lb_data[0] = bus.lb0_data;
    assign lb_data[1] = bus.lb1_data;
    assign lb_data[2] = bus.lb2_data;
    assign lb_data[3] = bus.lb3_data;

    assign rd_sel1 = rd_sel + 2'd1;
    assign rd_sel2 = rd_sel + 2'd2;

    // Zero-latency write path; gated by reset so nothing reaches the buffers
    // while they are held in reset.
    assign full            = (fill == FILL_FULL);
    assign accept          = bus.i_pixel_valid & ~full & reset_n;
    assign bus.lb_wr_data  = bus.i_pixel_data;
    assign bus.lb_wr_valid = accept ? (4'b0001 << wr_sel) : 4'b0000;
    assign bus.lb_rd       = rd_mask;

    assign bus.o_window       = window;
    assign bus.o_window_valid = window_valid;
    assign bus.o_intr         = intr;
    assign bus.o_overflow     = overflow;

    // Read FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Read FSM next state; all three active buffers advance together, which
    // keeps each buffer's read pointer on a line boundary.
    always_comb begin
        state_next = state;
        rd_mask    = 4'b0000;
        rd_cycle   = 1'b0;
        rd_last    = 1'b0;
        case (state)
            IDLE: begin
                if (fill >= FILL_START) begin
                    state_next = READ;
                end
            end
            READ: begin
                rd_cycle         = 1'b1;
                rd_mask[rd_sel]  = 1'b1;
                rd_mask[rd_sel1] = 1'b1;
                rd_mask[rd_sel2] = 1'b1;
                if (rd_col == COL_LAST) begin
                    rd_last    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write/read pointers, occupancy, window register and flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_sel       <= 2'd0;
            rd_sel       <= 2'd0;
            wr_col       <= '0;
            rd_col       <= '0;
            fill         <= '0;
            window       <= '0;
            window_valid <= 1'b0;
            intr         <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (accept) begin
                if (wr_col == COL_LAST) begin
                    wr_col <= '0;
                    wr_sel <= wr_sel + 2'd1;
                end else begin
                    wr_col <= wr_col + COL_W'(1);
                end
            end

            if (rd_cycle) begin
                if (rd_last) begin
                    rd_col <= '0;
                    rd_sel <= rd_sel + 2'd1;
                end else begin
                    rd_col <= rd_col + COL_W'(1);
                end
            end

            case ({accept, rd_cycle})
                2'b10:   fill <= fill + FILL_ONE;
                2'b01:   fill <= fill - FILL_ONE;
                default: fill <= fill;
            endcase

            // The last two columns straddle the line wrap and are dropped.
            if (rd_cycle && (rd_col <= COL_VLAST)) begin
                window       <= {lb_data[rd_sel], lb_data[rd_sel1], lb_data[rd_sel2]};
                window_valid <= 1'b1;
            end else begin
                window_valid <= 1'b0;
            end

            intr     <= rd_last;
            overflow <= overflow | (bus.i_pixel_valid & full);
        end
    end

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl with IMAGE_WIDTH = 8, including a
// behavioural model of the four line buffers.
module tb_line_buffer_ctrl;

    localparam int unsigned W = 8;

    logic clk;
    logic reset_n;

    line_buffer_ctrl_if bus ();

    line_buffer_ctrl #(.IMAGE_WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line buffer model: circular store, output {p[c],p[c+1],p[c+2]} at read pointer
    logic [7:0]  mem [4][W];
    logic [2:0]  wp [4];
    logic [2:0]  rp [4];
    logic [23:0] lbq [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < 4; b++) begin
                wp[b] <= 3'd0;
                rp[b] <= 3'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (bus.lb_wr_valid[b]) begin
                    mem[b][wp[b]] <= bus.lb_wr_data;
                    wp[b]         <= wp[b] + 3'd1;
                end
                if (bus.lb_rd[b]) begin
                    rp[b] <= rp[b] + 3'd1;
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) begin
            lbq[b] = {mem[b][rp[b]], mem[b][rp[b] + 3'd1], mem[b][rp[b] + 3'd2]};
        end
    end

    assign bus.lb0_data = lbq[0];
    assign bus.lb1_data = lbq[1];
    assign bus.lb2_data = lbq[2];
    assign bus.lb3_data = lbq[3];

    // Output monitor, sampled on the falling edge
    logic [71:0] win_q [$];
    logic [3:0]  wrv_q [$];
    logic [3:0]  rd_q  [$];
    logic [3:0]  prev_rd;
    int          intr_cnt;

    initial begin
        intr_cnt = 0;
        prev_rd  = 4'b0;
    end

    always @(negedge clk) begin
        if (bus.o_window_valid) win_q.push_back(bus.o_window);
        if (bus.o_intr) intr_cnt = intr_cnt + 1;
        if (bus.lb_wr_valid != 4'b0) wrv_q.push_back(bus.lb_wr_valid);
        if (bus.lb_rd != 4'b0 && prev_rd == 4'b0) rd_q.push_back(bus.lb_rd);
        prev_rd = bus.lb_rd;
    end

    int n_checks;
    int n_errors;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_checks = n_checks + 1;
        if (act !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.i_pixel_valid = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    // Stream n pixels starting at value 'first'; optional idle cycle between pixels
    task automatic send(input int first, input int n, input bit gap);
        for (int i = 0; i < n; i++) begin
            bus.i_pixel_data  = 8'(first + i);
            bus.i_pixel_valid = 1'b1;
            step();
            if (gap && i < n - 1) begin
                bus.i_pixel_valid = 1'b0;
                step();
            end
        end
        bus.i_pixel_valid = 1'b0;
    endtask

    task automatic wait_intr(input int target, input string name);
        int c;
        c = 0;
        while (intr_cnt < target && c < 80) begin
            step();
            c++;
        end
        n_checks = n_checks + 1;
        if (intr_cnt < target) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: o_intr count %0d expected %0d (timeout)", name, intr_cnt, target);
        end
    endtask

    function automatic logic [71:0] mkwin(input int a);
        return {8'(a), 8'(a + 1), 8'(a + 2), 8'(a + 8), 8'(a + 9), 8'(a + 10),
                8'(a + 16), 8'(a + 17), 8'(a + 18)};
    endfunction

    typedef struct {
        int          base;
        bit          gap;
        logic [71:0] first;
        logic [71:0] last;
    } scen_t;

    scen_t tbl [3];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, i0, q0, r0, c;

        n_checks = 0;
        n_errors = 0;

        tbl[0] = '{0,   1'b0, {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18},
                              {8'd5, 8'd6, 8'd7, 8'd13, 8'd14, 8'd15, 8'd21, 8'd22, 8'd23}};
        tbl[1] = '{0,   1'b1, {8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18},
                              {8'd5, 8'd6, 8'd7, 8'd13, 8'd14, 8'd15, 8'd21, 8'd22, 8'd23}};
        tbl[2] = '{100, 1'b1, {8'd100, 8'd101, 8'd102, 8'd108, 8'd109, 8'd110, 8'd116, 8'd117, 8'd118},
                              {8'd105, 8'd106, 8'd107, 8'd113, 8'd114, 8'd115, 8'd121, 8'd122, 8'd123}};

        // Reset held with pixels toggling
        reset_n = 1'b1;
        bus.i_pixel_data  = 8'h00;
        bus.i_pixel_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.i_pixel_valid = (i % 2 == 0);
            bus.i_pixel_data  = 8'(8'h5A + i);
            step();
            check("rst_wr_valid", 72'(bus.lb_wr_valid), 72'(0));
            check("rst_lb_rd", 72'(bus.lb_rd), 72'(0));
            check("rst_window", bus.o_window, 72'(0));
            check("rst_flags", 72'({bus.o_window_valid, bus.o_intr, bus.o_overflow}), 72'(0));
        end
        check("rst_wr_data", 72'(bus.lb_wr_data), 72'(8'h5D));
        bus.i_pixel_valid = 1'b0;
        reset_n = 1'b1;
        step();

        // Table: three lines, back-to-back / gapped / offset data
        for (int t = 0; t < 3; t++) begin
            do_reset();
            w0 = win_q.size();
            i0 = intr_cnt;
            send(tbl[t].base, 24, tbl[t].gap);
            step();
            check("lat1_valid", 72'(bus.o_window_valid), 72'(0));
            step();
            check("lat2_valid", 72'(bus.o_window_valid), 72'(1));
            check("lat2_window", bus.o_window, tbl[t].first);
            wait_intr(i0 + 1, "tbl_intr_wait");
            step();
            step();
            check("tbl_win_count", 72'(win_q.size() - w0), 72'(6));
            if (win_q.size() - w0 >= 6) begin
                check("tbl_first", win_q[w0], tbl[t].first);
                check("tbl_last", win_q[w0 + 5], tbl[t].last);
                for (int k = 1; k < 5; k++) check("tbl_mid", win_q[w0 + k], mkwin(tbl[t].base + k));
            end
            check("tbl_intr_once", 72'(intr_cnt - i0), 72'(1));
            check("tbl_fill", 72'(dut.fill), 72'(16));
            check("tbl_hold", bus.o_window, tbl[t].last);
        end

        // Rotation over five written lines
        do_reset();
        w0 = win_q.size();
        i0 = intr_cnt;
        q0 = wrv_q.size();
        r0 = rd_q.size();
        send(0, 24, 1'b0);
        wait_intr(i0 + 1, "rot_intr1");
        send(24, 8, 1'b0);
        wait_intr(i0 + 2, "rot_intr2");
        send(32, 8, 1'b0);
        wait_intr(i0 + 3, "rot_intr3");
        step();
        check("rot_wr_count", 72'(wrv_q.size() - q0), 72'(40));
        if (wrv_q.size() - q0 >= 40) begin
            check("rot_wrv0", 72'(wrv_q[q0]),      72'(4'b0001));
            check("rot_wrv1", 72'(wrv_q[q0 + 8]),  72'(4'b0010));
            check("rot_wrv2", 72'(wrv_q[q0 + 16]), 72'(4'b0100));
            check("rot_wrv3", 72'(wrv_q[q0 + 24]), 72'(4'b1000));
            check("rot_wrv4", 72'(wrv_q[q0 + 32]), 72'(4'b0001));
        end
        check("rot_rd_count", 72'(rd_q.size() - r0), 72'(3));
        if (rd_q.size() - r0 >= 3) begin
            check("rot_rd1", 72'(rd_q[r0]),     72'(4'b0111));
            check("rot_rd2", 72'(rd_q[r0 + 1]), 72'(4'b1110));
            check("rot_rd3", 72'(rd_q[r0 + 2]), 72'(4'b1101));
        end
        check("rot_win_count", 72'(win_q.size() - w0), 72'(18));
        if (win_q.size() - w0 >= 18) begin
            check("rot_line2_first", win_q[w0 + 6],
                  {8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18, 8'd24, 8'd25, 8'd26});
            check("rot_line3_first", win_q[w0 + 12],
                  {8'd16, 8'd17, 8'd18, 8'd24, 8'd25, 8'd26, 8'd32, 8'd33, 8'd34});
        end

        // Overflow: unthrottled stream until the bank is full
        do_reset();
        c = 0;
        bus.i_pixel_valid = 1'b1;
        while (dut.fill != 6'd32 && c < 400) begin
            bus.i_pixel_data = 8'(c);
            step();
            c++;
        end
        check("ovf_fill_reached", 72'(dut.fill), 72'(32));
        check("ovf_before", 72'(bus.o_overflow), 72'(0));
        check("ovf_drop", 72'(bus.lb_wr_valid), 72'(0));
        step();
        check("ovf_set", 72'(bus.o_overflow), 72'(1));
        for (int i = 0; i < 20; i++) step();
        check("ovf_sticky", 72'(bus.o_overflow), 72'(1));
        bus.i_pixel_valid = 1'b0;
        for (int i = 0; i < 30; i++) step();
        check("ovf_sticky_idle", 72'(bus.o_overflow), 72'(1));
        do_reset();
        check("ovf_cleared", 72'(bus.o_overflow), 72'(0));

        // Reset during READ at rd_col 3
        do_reset();
        send(0, 24, 1'b0);
        c = 0;
        while (!(bus.lb_rd != 4'b0 && dut.rd_col == 3'd3) && c < 40) begin
            step();
            c++;
        end
        check("midrd_reach", 72'(dut.rd_col), 72'(3));
        reset_n = 1'b0;
        #1;
        check("midrd_window", bus.o_window, 72'(0));
        check("midrd_flags", 72'({bus.o_window_valid, bus.o_intr, bus.o_overflow}), 72'(0));
        check("midrd_lb_rd", 72'(bus.lb_rd), 72'(0));
        step();
        step();
        reset_n = 1'b1;
        step();
        w0 = win_q.size();
        i0 = intr_cnt;
        send(100, 24, 1'b0);
        wait_intr(i0 + 1, "midrd_intr");
        step();
        check("midrd_win_count", 72'(win_q.size() - w0), 72'(6));
        if (win_q.size() - w0 >= 1) begin
            check("midrd_first", win_q[w0],
                  {8'd100, 8'd101, 8'd102, 8'd108, 8'd109, 8'd110, 8'd116, 8'd117, 8'd118});
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Sequencing controller for a bank of four `line_buffer` instances feeding a 3x3 spatial filter. It steers incoming pixels into the buffers one line at a time in rotation. Once three full lines are stored, it reads three buffers in lockstep to emit one 72-bit 3x3 window per clock. After each line is consumed it pulses an interrupt so upstream can send another line.

## Interface
- `IMAGE_WIDTH`, 512: pixels per line. Must equal the `IMAGE_WIDTH` of all four line buffers; minimum 4.
- `clk` in 1: system clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset. The same net drives the reset of all four line buffers.
- `i_pixel_data` in 8: incoming pixel.
- `i_pixel_valid` in 1: pixel qualifier, one pixel per cycle when high.
- `lb_wr_data` out 8: combinational pass-through of `i_pixel_data`.
- `lb_wr_valid` out 4: one-hot write enable to buffers 0..3.
- `lb_rd` out 4: read-advance strobes to buffers 0..3.
- `lb0_data`..`lb3_data` in 24 each: buffer outputs, `{p[c],p[c+1],p[c+2]}`.
- `o_window` out 72: registered 3x3 window.
- `o_window_valid` out 1: window qualifier.
- `o_intr` out 1: one-cycle pulse when a line slot is freed.
- `o_overflow` out 1: sticky error flag, cleared only by reset.

## Operation
- **Write side**
  - `wr_sel` (2b) selects the target buffer. `wr_col` counts 0..IMAGE_WIDTH-1.
  - An accepted pixel (`i_pixel_valid & !full`) sets `lb_wr_valid[wr_sel]` and increments `wr_col`.
  - At `wr_col == IMAGE_WIDTH-1`, `wr_col` returns to 0 and `wr_sel` advances mod 4 (3 -> 0).
- **Occupancy**
  - `fill` has width $clog2(4*IMAGE_WIDTH+1) and range 0..4*IMAGE_WIDTH.
  - +1 per accepted write, -1 per read cycle, unchanged when both occur in the same cycle.
  - `full = (fill == 4*IMAGE_WIDTH)`.
  - A pixel presented while full is dropped: no `lb_wr_valid`, and `o_overflow` is set.
- **Read FSM**, two states:
  - IDLE -> READ when `fill >= 3*IMAGE_WIDTH`, evaluated on the registered `fill`.
  - READ lasts exactly IMAGE_WIDTH cycles, with `rd_col` counting 0..IMAGE_WIDTH-1.
  - Each READ cycle asserts `lb_rd` bits `rd_sel`, `rd_sel+1` and `rd_sel+2` (mod 4) combinationally. This keeps buffer read pointers aligned across the wrap.
  - READ -> IDLE after `rd_col == IMAGE_WIDTH-1`. On that transition `rd_sel` advances mod 4 and `o_intr` pulses for 1 cycle.
  - IDLE always lasts at least 1 cycle.
- **Window assembly**, registered on each READ cycle:
  - `o_window[71:48]` = buffer `rd_sel` (oldest line).
  - `o_window[47:24]` = buffer `rd_sel+1`.
  - `o_window[23:0]` = buffer `rd_sel+2`.
  - `o_window_valid <= (rd_col <= IMAGE_WIDTH-3)`. The last two columns contain wrapped data and are suppressed.
  - `o_window` holds its value when not valid.
- **Reset** (asynchronous, any state including mid-READ):
  - State -> IDLE.
  - `wr_sel`, `rd_sel`, `wr_col`, `rd_col`, `fill` -> 0.
  - `o_window` = 0, `o_window_valid` = 0, `o_intr` = 0, `o_overflow` = 0.
  - After reset, three fresh lines are required before any window is produced.

## Timing
- Write path is zero latency: `lb_wr_valid` and `lb_wr_data` are asserted in the same cycle as `i_pixel_valid`.
- First window: `o_window_valid` rises 2 clocks after the edge that accepted pixel 3*IMAGE_WIDTH. That is 1 cycle for the IDLE decision and 1 cycle for the window register.
- Window latency is 1 clock from the `lb_rd` cycle to `o_window`.
- Per line: IMAGE_WIDTH-2 consecutive valid windows, followed by 2 invalid cycles.
- `o_intr` is high during the single IDLE cycle following each READ.
- Minimum line period is IMAGE_WIDTH+1 cycles. A continuous 1-pixel-per-cycle source gains net +1 occupancy per line and must throttle on `o_intr`; otherwise `o_overflow` eventually sets.
- Pending reads and writes never stall each other.

## Test plan
- **Reset:** hold `reset_n` low with pixels toggling -> all outputs 0, `lb_wr_valid` = 0, `lb_rd` = 0.
- **First three lines:** IMAGE_WIDTH=8, stream 24 pixels with value = index, back-to-back.
  - First valid window 2 clocks after pixel 23 = {0,1,2, 8,9,10, 16,17,18}.
  - 6 valid windows in total, last = {5,6,7, 13,14,15, 21,22,23}.
  - `o_intr` pulses once; `fill` = 16 afterwards.
- **Rotation:** IMAGE_WIDTH=8, stream 40 pixels with waits on `o_intr`.
  - Second line windows start {8,9,10, 16,17,18, 24,25,26}.
  - `lb_wr_valid` walks 0001 -> 0010 -> 0100 -> 1000 -> 0001.
  - `lb_rd` = 0111 on line 1, 1110 on line 2.
- **Gapped input:** same data as the first-three-lines scenario with `i_pixel_valid` toggling 1/0 -> identical window sequence and values.
- **Overflow:** IMAGE_WIDTH=8, continuous valid stream without throttling until `fill` = 32 -> the next pixel gets `lb_wr_valid` = 0 and `o_overflow` goes high and stays high until reset.
- **Reset mid-READ:** pulse `reset_n` low at `rd_col` = 3 -> outputs 0 within the same cycle. After release, 24 new pixels (value = index + 100) give a first window of {100,101,102, 108,109,110, 116,117,118}.
